multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
- Parametrised multi-cycle successor to the single-cycle RV32I main decoder.
- A Moore FSM sequences each instruction through FETCH/DECODE/EXEC/MEM/WB, waits on a memory ready handshake, and traps on illegal opcodes.
- Keeps a retired-instruction counter.
- Sits between instruction/data memory and the multi-cycle datapath (PC, IR, ALUOut, register file).

Parameters:
- MEM_HANDSHAKE, 1: 1 = wait on mem_ready; 0 = mem_ready is ignored and treated as 1.
- TRAP_STICKY, 1: 1 = TRAP is held until reset; 0 = TRAP lasts one cycle, then goes to FETCH.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  clock
- arst_n  in  1  asynchronous active-low reset
- opcode  in  7  IR[6:0]; valid from DECODE onward
- mem_ready  in  1  memory completes the current request this cycle
- branch_cond  in  1  datapath branch comparison result (funct3-resolved)
- mem_req  out  1  memory access request
- mem_we  out  1  write strobe (store)
- ir_write  out  1  load IR
- pc_write  out  1  load PC
- pc_src  out  2  0 = ALU result, 1 = ALUOut, 2 = ALU result with bit0 cleared
- alusrc_a  out  2  0 = PC, 1 = rs1, 2 = old PC, 3 = zero
- alusrc_b  out  2  0 = rs2, 1 = const 4, 2 = imm
- aluop  out  2  0 = ADD, 1 = BRANCH compare, 2 = FUNCT decode
- wb_sel  out  2  0 = ALUOut, 1 = memory data, 2 = PC (+4)
- regwrite  out  1  register file write
- branch  out  1  branch instruction in EXEC
- illegal  out  1  high in TRAP
- retire  out  1  one-cycle pulse when an instruction completes
- retired_cnt  out  CNT_W  count of retire pulses

Behaviour:
- Reset (arst_n low, asynchronous): state = IDLE, opcode_q = 0, retired_cnt = 0; all outputs 0.
- Output decode: every output is a combinational decode of state_q and opcode_q. The only exceptions are the stated mem_ready and branch_cond gating.
- Unlisted outputs are 0 in every state.
- IDLE: all outputs 0; next state is always FETCH.
- FETCH:
  - mem_req = 1, alusrc_a = 0, alusrc_b = 1, aluop = ADD, pc_src = 0.
  - ir_write = pc_write = mem_ready.
  - Stay in FETCH while mem_ready = 0; go to DECODE when it is 1.
- DECODE:
  - alusrc_a = 2, alusrc_b = 2, aluop = ADD (precomputes the branch/JAL target into ALUOut).
  - opcode_q <= opcode.
  - Next state: EXEC if the opcode is one of the 9 RV32I classes, else TRAP.
- EXEC, by opcode_q:
  - R: a = 1, b = 0, aluop = FUNCT; next WB.
  - I: a = 1, b = 2, aluop = FUNCT; next WB.
  - LOAD / STORE: a = 1, b = 2, aluop = ADD; next MEM.
  - B: a = 1, b = 0, aluop = BRANCH, branch = 1, pc_src = 1, pc_write = branch_cond; retire; next FETCH.
  - JAL: pc_src = 1, pc_write = 1, regwrite = 1, wb_sel = 2; retire; next FETCH.
  - JALR: a = 1, b = 2, aluop = ADD, pc_src = 2, pc_write = 1, regwrite = 1, wb_sel = 2; retire; next FETCH.
  - LUI: a = 3, b = 2, ADD; next WB.
  - AUIPC: a = 2, b = 2, ADD; next WB.
- MEM:
  - mem_req = 1, mem_we = (opcode_q == STORE).
  - Stay while mem_ready = 0.
  - On mem_ready: store retires and goes to FETCH; load goes to WB.
- WB:
  - regwrite = 1, wb_sel = 1 for load, else 0; retire; next FETCH.
  - For JAL/JALR, the writeback in EXEC sees the PC register still holding old PC + 4, because the PC update lands at the end of EXEC.
- TRAP: illegal = 1, no retire. TRAP_STICKY = 1 holds TRAP; TRAP_STICKY = 0 goes to FETCH next cycle.
- Latency in cycles with zero-wait memory, counted from FETCH entry:
  - B / JAL / JALR: 3
  - R / I / LUI / AUIPC / STORE: 4
  - LOAD: 5
- Each memory wait cycle adds 1.
- retired_cnt increments on every retire pulse and wraps modulo 2^CNT_W.
- Reset asserted mid-instruction aborts immediately to IDLE; no partial retire.
- mem_ready high outside FETCH/MEM is ignored.

Decomposition:
- Package cu_pkg holds:
  - opcode localparams (R_TYPE 0110011, I_LOAD 0000011, I_TYPE 0010011, S_TYPE 0100011, B_TYPE 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111);
  - state_t enum;
  - aluop_t, alusrc_a_t, alusrc_b_t, wb_sel_t, pc_src_t enums.
- One sub-module, cu_retire_counter (CNT_W counter with enable), is natural. The FSM stays in the top module.

Test Plan:
- Reset: hold arst_n = 0, then release with mem_ready = 1 and an R opcode (0110011). Expect IDLE, then FETCH (ir_write = pc_write = 1), DECODE, EXEC (aluop = 2), WB (regwrite = 1), with retire in WB and retired_cnt = 1.
- LOAD (0000011), mem_ready low 2 cycles in MEM: mem_req held 3 cycles, mem_we = 0, WB wb_sel = 1, 7 cycles total, retire once.
- B_TYPE (1100011) twice: branch_cond = 1 gives pc_write = 1 and pc_src = 1 in EXEC; branch_cond = 0 gives pc_write = 0. Both take 3 cycles and retire.
- JALR (1100111): in EXEC, pc_src = 2, pc_write = regwrite = 1, wb_sel = 2. Next state FETCH.
- Opcode 1111111: DECODE goes to TRAP with illegal = 1 held ≥10 cycles (TRAP_STICKY = 1). With TRAP_STICKY = 0, illegal lasts 1 cycle, then FETCH, and retired_cnt is unchanged.
- CNT_W = 2 and five zero-wait STOREs (0100011): mem_we = 1 in each MEM; retired_cnt goes 1, 2, 3, 0, 1. Asserting arst_n mid-MEM gives IDLE and count 0.

Source files
------------

// File: rtl/cu_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: opcodes, FSM states
// and the datapath select fields driven by the controller.
package cu_pkg;

    localparam logic [6:0] R_TYPE = 7'b0110011;
    localparam logic [6:0] I_LOAD = 7'b0000011;
    localparam logic [6:0] I_TYPE = 7'b0010011;
    localparam logic [6:0] S_TYPE = 7'b0100011;
    localparam logic [6:0] B_TYPE = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        ALU_ADD    = 2'd0,
        ALU_BRANCH = 2'd1,
        ALU_FUNCT  = 2'd2
    } aluop_t;

    typedef enum logic [1:0] {
        A_PC     = 2'd0,
        A_RS1    = 2'd1,
        A_OLD_PC = 2'd2,
        A_ZERO   = 2'd3
    } alusrc_a_t;

    typedef enum logic [1:0] {
        B_RS2  = 2'd0,
        B_FOUR = 2'd1,
        B_IMM  = 2'd2
    } alusrc_b_t;

    typedef enum logic [1:0] {
        WB_ALUOUT = 2'd0,
        WB_MEM    = 2'd1,
        WB_PC4    = 2'd2
    } wb_sel_t;

    typedef enum logic [1:0] {
        PC_ALU      = 2'd0,
        PC_ALUOUT   = 2'd1,
        PC_ALU_LSB0 = 2'd2
    } pc_src_t;

    function automatic logic is_legal_op(input logic [6:0] op);
        case (op)
            R_TYPE, I_LOAD, I_TYPE, S_TYPE, B_TYPE,
            JAL, JALR, LUI, AUIPC: is_legal_op = 1'b1;
            default:               is_legal_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cu_retire_counter.sv
// Free-running retired-instruction counter; wraps modulo 2^CNT_W.
module cu_retire_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore FSM sequencing RV32I instructions through FETCH/DECODE/EXEC/MEM/WB
// with a memory ready handshake, illegal-opcode trap and retire counter.
//
// state  | meaning
// IDLE   | first cycle out of reset, no activity
// FETCH  | read instruction, PC <= PC + 4 when memory is ready
// DECODE | latch opcode, precompute PC-relative target into ALUOut
// EXEC   | ALU operation; branches and jumps complete here
// MEM    | data load/store access, waits on memory ready
// WB     | register file writeback
// TRAP   | illegal opcode seen
module multicycle_control_unit
    import cu_pkg::*;
#(
    parameter bit MEM_HANDSHAKE = 1'b1,
    parameter bit TRAP_STICKY   = 1'b1,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic [6:0]       opcode,
    input  logic             mem_ready,
    input  logic             branch_cond,
    output logic             mem_req,
    output logic             mem_we,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic [1:0]       alusrc_a,
    output logic [1:0]       alusrc_b,
    output logic [1:0]       aluop,
    output logic [1:0]       wb_sel,
    output logic             regwrite,
    output logic             branch,
    output logic             illegal,
    output logic             retire,
    output logic [CNT_W-1:0] retired_cnt
);

    state_t    state_q, state_d;
    logic [6:0] opcode_q;
    logic      mem_rdy;
    pc_src_t   pc_src_e;
    alusrc_a_t alusrc_a_e;
    alusrc_b_t alusrc_b_e;
    aluop_t    aluop_e;
    wb_sel_t   wb_sel_e;

    assign mem_rdy = MEM_HANDSHAKE ? mem_ready : 1'b1;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q  <= S_IDLE;
            opcode_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                opcode_q <= opcode;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src_e   = PC_ALU;
        alusrc_a_e = A_PC;
        alusrc_b_e = B_RS2;
        aluop_e    = ALU_ADD;
        wb_sel_e   = WB_ALUOUT;
        regwrite   = 1'b0;
        branch     = 1'b0;
        illegal    = 1'b0;
        retire     = 1'b0;

        case (state_q)
            S_IDLE: state_d = S_FETCH;

            S_FETCH: begin
                mem_req    = 1'b1;
                alusrc_a_e = A_PC;
                alusrc_b_e = B_FOUR;
                ir_write   = mem_rdy;
                pc_write   = mem_rdy;
                if (mem_rdy) state_d = S_DECODE;
            end

            S_DECODE: begin
                alusrc_a_e = A_OLD_PC;
                alusrc_b_e = B_IMM;
                state_d    = is_legal_op(opcode) ? S_EXEC : S_TRAP;
            end

            S_EXEC: begin
                case (opcode_q)
                    R_TYPE: begin
                        alusrc_a_e = A_RS1;
                        aluop_e    = ALU_FUNCT;
                        state_d    = S_WB;
                    end
                    I_TYPE: begin
                        alusrc_a_e = A_RS1;
                        alusrc_b_e = B_IMM;
                        aluop_e    = ALU_FUNCT;
                        state_d    = S_WB;
                    end
                    I_LOAD, S_TYPE: begin
                        alusrc_a_e = A_RS1;
                        alusrc_b_e = B_IMM;
                        state_d    = S_MEM;
                    end
                    B_TYPE: begin
                        alusrc_a_e = A_RS1;
                        aluop_e    = ALU_BRANCH;
                        branch     = 1'b1;
                        pc_src_e   = PC_ALUOUT;
                        pc_write   = branch_cond;
                        retire     = 1'b1;
                        state_d    = S_FETCH;
                    end
                    // PC register still holds old PC + 4 here, so WB_PC4 links correctly.
                    JAL: begin
                        pc_src_e = PC_ALUOUT;
                        pc_write = 1'b1;
                        regwrite = 1'b1;
                        wb_sel_e = WB_PC4;
                        retire   = 1'b1;
                        state_d  = S_FETCH;
                    end
                    JALR: begin
                        alusrc_a_e = A_RS1;
                        alusrc_b_e = B_IMM;
                        pc_src_e   = PC_ALU_LSB0;
                        pc_write   = 1'b1;
                        regwrite   = 1'b1;
                        wb_sel_e   = WB_PC4;
                        retire     = 1'b1;
                        state_d    = S_FETCH;
                    end
                    LUI: begin
                        alusrc_a_e = A_ZERO;
                        alusrc_b_e = B_IMM;
                        state_d    = S_WB;
                    end
                    AUIPC: begin
                        alusrc_a_e = A_OLD_PC;
                        alusrc_b_e = B_IMM;
                        state_d    = S_WB;
                    end
                    default: state_d = S_TRAP;
                endcase
            end

            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = (opcode_q == S_TYPE);
                if (mem_rdy) begin
                    if (opcode_q == S_TYPE) begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end

            S_WB: begin
                regwrite = 1'b1;
                wb_sel_e = (opcode_q == I_LOAD) ? WB_MEM : WB_ALUOUT;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end

            S_TRAP: begin
                illegal = 1'b1;
                state_d = TRAP_STICKY ? S_TRAP : S_FETCH;
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign pc_src   = pc_src_e;
    assign alusrc_a = alusrc_a_e;
    assign alusrc_b = alusrc_b_e;
    assign aluop    = aluop_e;
    assign wb_sel   = wb_sel_e;

    cu_retire_counter #(
        .CNT_W(CNT_W)
    ) u_retire_counter (
        .clk   (clk),
        .arst_n(arst_n),
        .en    (retire),
        .count (retired_cnt)
    );

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: per-cycle expected outputs are
// queued as stimulus is planned, then popped and compared cycle by cycle.
module tb_multicycle_control_unit;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_ST   = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_AUI  = 7'b0010111;
    localparam logic [6:0] OP_BAD  = 7'b1111111;

    typedef struct {
        logic        mr;
        logic        bc;
        logic [6:0]  op;
        logic [17:0] exp;
        logic [31:0] cnt;
        string       tag;
    } ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       arst0, arst1, arst2;
    logic [6:0] opcode;
    logic       mem_ready, branch_cond;
    wire [17:0] o0, o1, o2;
    wire [31:0] c0, c1;
    wire [1:0]  c2;

    int          sel;
    int          total = 0;
    int          bad = 0;
    ent_t        sb[$];
    logic [31:0] cnt_model, cnt_mask;

    // Output vector: {mem_req, mem_we, ir_write, pc_write, pc_src, alusrc_a,
    //                 alusrc_b, aluop, wb_sel, regwrite, branch, illegal, retire}
    multicycle_control_unit dut0 (
        .clk(clk), .arst_n(arst0), .opcode(opcode), .mem_ready(mem_ready),
        .branch_cond(branch_cond), .mem_req(o0[17]), .mem_we(o0[16]),
        .ir_write(o0[15]), .pc_write(o0[14]), .pc_src(o0[13:12]),
        .alusrc_a(o0[11:10]), .alusrc_b(o0[9:8]), .aluop(o0[7:6]),
        .wb_sel(o0[5:4]), .regwrite(o0[3]), .branch(o0[2]), .illegal(o0[1]),
        .retire(o0[0]), .retired_cnt(c0)
    );

    multicycle_control_unit #(.TRAP_STICKY(1'b0)) dut1 (
        .clk(clk), .arst_n(arst1), .opcode(opcode), .mem_ready(mem_ready),
        .branch_cond(branch_cond), .mem_req(o1[17]), .mem_we(o1[16]),
        .ir_write(o1[15]), .pc_write(o1[14]), .pc_src(o1[13:12]),
        .alusrc_a(o1[11:10]), .alusrc_b(o1[9:8]), .aluop(o1[7:6]),
        .wb_sel(o1[5:4]), .regwrite(o1[3]), .branch(o1[2]), .illegal(o1[1]),
        .retire(o1[0]), .retired_cnt(c1)
    );

    multicycle_control_unit #(.CNT_W(2)) dut2 (
        .clk(clk), .arst_n(arst2), .opcode(opcode), .mem_ready(mem_ready),
        .branch_cond(branch_cond), .mem_req(o2[17]), .mem_we(o2[16]),
        .ir_write(o2[15]), .pc_write(o2[14]), .pc_src(o2[13:12]),
        .alusrc_a(o2[11:10]), .alusrc_b(o2[9:8]), .aluop(o2[7:6]),
        .wb_sel(o2[5:4]), .regwrite(o2[3]), .branch(o2[2]), .illegal(o2[1]),
        .retire(o2[0]), .retired_cnt(c2)
    );

    function automatic logic [17:0] cur_out();
        case (sel)
            1:       return o1;
            2:       return o2;
            default: return o0;
        endcase
    endfunction

    function automatic logic [31:0] cur_cnt();
        case (sel)
            1:       return c1;
            2:       return {30'd0, c2};
            default: return c0;
        endcase
    endfunction

    function automatic logic [17:0] mk(
        input logic req, input logic we, input logic irw, input logic pcw,
        input logic [1:0] pcs, input logic [1:0] a, input logic [1:0] b,
        input logic [1:0] alu, input logic [1:0] wb, input logic rw,
        input logic br, input logic ill, input logic ret);
        return {req, we, irw, pcw, pcs, a, b, alu, wb, rw, br, ill, ret};
    endfunction

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push(input logic mr, input logic bc, input logic [6:0] op,
                        input logic [17:0] exp, input string tag);
        ent_t e;
        e.mr = mr; e.bc = bc; e.op = op; e.exp = exp; e.cnt = cnt_model; e.tag = tag;
        sb.push_back(e);
        if (exp[0]) cnt_model = (cnt_model + 32'd1) & cnt_mask;
    endtask

    task automatic push_front_end(input logic [6:0] op, input int fw, input logic bc);
        for (int i = 0; i < fw; i++)
            push(1'b0, bc, op, mk(1,0,0,0, 2'd0,2'd0,2'd1,2'd0,2'd0, 0,0,0,0), "fetch_wait");
        push(1'b1, bc, op, mk(1,0,1,1, 2'd0,2'd0,2'd1,2'd0,2'd0, 0,0,0,0), "fetch");
        push(rnd(), bc, op, mk(0,0,0,0, 2'd0,2'd2,2'd2,2'd0,2'd0, 0,0,0,0), "decode");
    endtask

    task automatic push_instr(input logic [6:0] op, input int fw, input int mw, input logic bc);
        int path;   // 0 = WB next, 1 = MEM next, 2 = done in EXEC
        push_front_end(op, fw, bc);
        path = 0;
        case (op)
            OP_R:    push(rnd(), bc, op, mk(0,0,0,0, 2'd0,2'd1,2'd0,2'd2,2'd0, 0,0,0,0), "exec_r");
            OP_I:    push(rnd(), bc, op, mk(0,0,0,0, 2'd0,2'd1,2'd2,2'd2,2'd0, 0,0,0,0), "exec_i");
            OP_LUI:  push(rnd(), bc, op, mk(0,0,0,0, 2'd0,2'd3,2'd2,2'd0,2'd0, 0,0,0,0), "exec_lui");
            OP_AUI:  push(rnd(), bc, op, mk(0,0,0,0, 2'd0,2'd2,2'd2,2'd0,2'd0, 0,0,0,0), "exec_auipc");
            OP_LD, OP_ST: begin
                push(rnd(), bc, op, mk(0,0,0,0, 2'd0,2'd1,2'd2,2'd0,2'd0, 0,0,0,0), "exec_mem");
                path = 1;
            end
            OP_B: begin
                push(rnd(), bc, op, mk(0,0,0,bc, 2'd1,2'd1,2'd0,2'd1,2'd0, 0,1,0,1), "exec_b");
                path = 2;
            end
            OP_JAL: begin
                push(rnd(), bc, op, mk(0,0,0,1, 2'd1,2'd0,2'd0,2'd0,2'd2, 1,0,0,1), "exec_jal");
                path = 2;
            end
            default: begin
                push(rnd(), bc, op, mk(0,0,0,1, 2'd2,2'd1,2'd2,2'd0,2'd2, 1,0,0,1), "exec_jalr");
                path = 2;
            end
        endcase
        if (path == 1) begin
            for (int i = 0; i < mw; i++)
                push(1'b0, bc, op, mk(1, op == OP_ST,0,0, 2'd0,2'd0,2'd0,2'd0,2'd0, 0,0,0,0), "mem_wait");
            push(1'b1, bc, op, mk(1, op == OP_ST,0,0, 2'd0,2'd0,2'd0,2'd0,2'd0, 0,0,0, op == OP_ST), "mem");
        end
        if (path == 0 || (path == 1 && op == OP_LD))
            push(rnd(), bc, op, mk(0,0,0,0, 2'd0,2'd0,2'd0,2'd0, (op == OP_LD) ? 2'd1 : 2'd0, 1,0,0,1), "wb");
    endtask

    task automatic drain();
        ent_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk);
            mem_ready   = e.mr;
            branch_cond = e.bc;
            opcode      = e.op;
            #1;
            total++;
            if (cur_out() !== e.exp || cur_cnt() !== e.cnt) begin
                bad++;
                $display("FAIL %s @%0t: out=%h cnt=%0d expected out=%h cnt=%0d",
                         e.tag, $time, cur_out(), cur_cnt(), e.exp, e.cnt);
            end
        end
    endtask

    task automatic check_reset_state(input string tag);
        total++;
        if (cur_out() !== 18'd0 || cur_cnt() !== 32'd0) begin
            bad++;
            $display("FAIL %s: out=%h cnt=%0d expected out=0 cnt=0", tag, cur_out(), cur_cnt());
        end
    endtask

    task automatic start(input int s, input logic [31:0] mask);
        sel = s;
        arst0 = 1'b0; arst1 = 1'b0; arst2 = 1'b0;
        @(negedge clk);
        mem_ready = 1'b1; opcode = OP_R; branch_cond = 1'b0;
        #1;
        check_reset_state("reset_hold");
        @(posedge clk);
        #2;
        case (s)
            1:       arst1 = 1'b1;
            2:       arst2 = 1'b1;
            default: arst0 = 1'b1;
        endcase
        cnt_model = 32'd0;
        cnt_mask  = mask;
        push(1'b1, 1'b0, OP_R, 18'd0, "idle");
    endtask

    task automatic async_reset(input string tag);
        @(negedge clk);
        #3;
        arst0 = 1'b0; arst1 = 1'b0; arst2 = 1'b0;
        #1;
        check_reset_state(tag);
    endtask

    task automatic test_reset();
        start(0, 32'hFFFF_FFFF);
        push_instr(OP_R, 0, 0, 1'b0);
        drain();
    endtask

    task automatic test_load();
        push_instr(OP_LD, 0, 2, 1'b0);
        push_instr(OP_LD, 1, 0, 1'b1);
        drain();
    endtask

    task automatic test_branch();
        push_instr(OP_B, 0, 0, 1'b1);
        push_instr(OP_B, 0, 0, 1'b0);
        drain();
    endtask

    task automatic test_back_to_back();
        push_instr(OP_JALR, 0, 0, 1'b0);
        push_instr(OP_JAL,  2, 0, 1'b1);
        push_instr(OP_I,    0, 0, 1'b0);
        push_instr(OP_LUI,  1, 0, 1'b0);
        push_instr(OP_AUI,  0, 0, 1'b1);
        push_instr(OP_ST,   0, 1, 1'b0);
        drain();
    endtask

    task automatic test_trap_sticky();
        push_front_end(OP_BAD, 0, 1'b0);
        for (int i = 0; i < 12; i++)
            push(rnd(), 1'b0, OP_BAD, mk(0,0,0,0, 2'd0,2'd0,2'd0,2'd0,2'd0, 0,0,1,0), "trap_sticky");
        drain();
        async_reset("trap_reset");
    endtask

    task automatic test_trap_oneshot();
        start(1, 32'hFFFF_FFFF);
        push_instr(OP_R, 0, 0, 1'b0);
        push_front_end(OP_BAD, 0, 1'b0);
        push(1'b1, 1'b0, OP_BAD, mk(0,0,0,0, 2'd0,2'd0,2'd0,2'd0,2'd0, 0,0,1,0), "trap_once");
        push_instr(OP_I, 0, 0, 1'b0);
        push(1'b0, 1'b0, OP_I, mk(1,0,0,0, 2'd0,2'd0,2'd1,2'd0,2'd0, 0,0,0,0), "fetch_after");
        drain();
    endtask

    task automatic test_counter_wrap();
        start(2, 32'd3);
        for (int i = 0; i < 5; i++) push_instr(OP_ST, 0, 0, 1'b0);
        push_front_end(OP_ST, 0, 1'b0);
        push(1'b1, 1'b0, OP_ST, mk(0,0,0,0, 2'd0,2'd1,2'd2,2'd0,2'd0, 0,0,0,0), "exec_st");
        push(1'b0, 1'b0, OP_ST, mk(1,1,0,0, 2'd0,2'd0,2'd0,2'd0,2'd0, 0,0,0,0), "mem_wait_st");
        drain();
        total++;
        if (cur_cnt() !== 32'd1) begin
            bad++;
            $display("FAIL wrap_count: cnt=%0d expected 1", cur_cnt());
        end
        async_reset("mid_mem_reset");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        arst0 = 1'b0; arst1 = 1'b0; arst2 = 1'b0;
        opcode = OP_R; mem_ready = 1'b0; branch_cond = 1'b0;
        sel = 0; cnt_model = 32'd0; cnt_mask = 32'hFFFF_FFFF;
        test_reset();
        test_load();
        test_branch();
        test_back_to_back();
        test_trap_sticky();
        test_trap_oneshot();
        test_counter_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
